// File: rtl/frost32_mem_access_unit_if.sv
// CPU request port and memory bus of the Frost32 load/store unit.
// cpu_sign_ext is present only when FROST32_MEM_ACCESS_SIGN_EXT_EN is defined.
interface frost32_mem_access_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   // Handshakes: cpu_req is a one-cycle strobe taken only while the unit is idle
   // (not cpu_busy, no done/fault pulse); otherwise it is dropped, never queued.
   // mem_req is held high with mem_we/addr/wdata/byte_en stable until the cycle
   // mem_ack is seen (or the timeout expires); mem_rdata is valid only with mem_ack.
   logic                    cpu_req;
   logic                    cpu_access_type;
   logic [1:0]              cpu_access_size;
   logic [ADDR_WIDTH-1:0]   cpu_addr;
   logic [DATA_WIDTH-1:0]   cpu_wdata;
`ifdef FROST32_MEM_ACCESS_SIGN_EXT_EN
   logic                    cpu_sign_ext;
`endif
   logic                    cpu_busy;
   logic                    cpu_done;
   logic [DATA_WIDTH-1:0]   cpu_rdata;
   logic                    cpu_fault;
   logic [1:0]              cpu_fault_code;
   logic                    mem_req;
   logic                    mem_we;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [DATA_WIDTH/8-1:0] mem_byte_en;
   logic                    mem_ack;
   logic [DATA_WIDTH-1:0]   mem_rdata;

   modport master (
`ifdef FROST32_MEM_ACCESS_SIGN_EXT_EN
      input  cpu_sign_ext,
`endif
      input  cpu_req, cpu_access_type, cpu_access_size, cpu_addr, cpu_wdata,
      output cpu_busy, cpu_done, cpu_rdata, cpu_fault, cpu_fault_code,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
      input  mem_ack, mem_rdata
   );

   modport slave (
`ifdef FROST32_MEM_ACCESS_SIGN_EXT_EN
      output cpu_sign_ext,
`endif
      output cpu_req, cpu_access_type, cpu_access_size, cpu_addr, cpu_wdata,
      input  cpu_busy, cpu_done, cpu_rdata, cpu_fault, cpu_fault_code,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_byte_en,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/frost32_mem_access_unit.sv
// Frost32 load/store bus unit: size/alignment checks, byte enables, wait states, timeout.
// Define FROST32_MEM_ACCESS_SIGN_EXT_EN to add cpu_sign_ext for signed 8b/16b loads.
module frost32_mem_access_unit #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst_n,
   frost32_mem_access_unit_if.master bus,
   output logic [1:0]                dbg_state
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int OW = $clog2(NB);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DONE  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            code_q, code_d;
   logic [CW-1:0]         cnt_q;
   logic                  we_q;
   logic [1:0]            size_q;
   logic [OW-1:0]         off_q;
   logic                  sext_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NB-1:0]         be_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   logic                  accept;
   logic                  bad_size;
   logic                  misaligned;
   logic                  timeout_hit;
   logic                  req_sext;
   logic [OW-1:0]         req_off;
   logic [NB-1:0]         req_be;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [DATA_WIDTH-1:0] rd_shift, rd_mask, rd_ext;
   logic                  rd_sign;

   assign accept      = (state_q == S_IDLE) && bus.cpu_req;
   assign req_off     = bus.cpu_addr[OW-1:0];
   assign bad_size    = (bus.cpu_access_size == 2'd3);
   assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign dbg_state   = state_q;

`ifdef FROST32_MEM_ACCESS_SIGN_EXT_EN
   assign req_sext = bus.cpu_sign_ext;
`else
   assign req_sext = 1'b0;
`endif

   always_comb begin
      misaligned = 1'b0;
      req_be     = '0;
      req_wdata  = '0;
      case (bus.cpu_access_size)
         2'd0: begin
            misaligned = (bus.cpu_addr[1:0] != 2'b00);
            req_be     = NB'(4'hF) << req_off;
         end
         2'd1: begin
            misaligned = bus.cpu_addr[0];
            req_be     = NB'(2'b11) << req_off;
         end
         default: req_be = NB'(1'b1) << req_off;
      endcase
      // Replicate the access-sized chunk into every lane so any offset sees it.
      for (int i = 0; i < NB; i++) begin
         case (bus.cpu_access_size)
            2'd1:    req_wdata[i*8 +: 8] = bus.cpu_wdata[(i % 2)*8 +: 8];
            2'd2:    req_wdata[i*8 +: 8] = bus.cpu_wdata[7:0];
            default: req_wdata[i*8 +: 8] = bus.cpu_wdata[(i % 4)*8 +: 8];
         endcase
      end
   end

   always_comb begin
      rd_shift = bus.mem_rdata >> {off_q, 3'b000};
      rd_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
      rd_sign  = 1'b0;
      case (size_q)
         2'd1: begin
            rd_mask = DATA_WIDTH'(16'hFFFF);
            rd_sign = rd_shift[15];
         end
         2'd2: begin
            rd_mask = DATA_WIDTH'(8'hFF);
            rd_sign = rd_shift[7];
         end
         default: ;
      endcase
      rd_ext = (rd_shift & rd_mask) | ((sext_q && rd_sign) ? ~rd_mask : '0);
   end

   always_comb begin
      state_d            = state_q;
      code_d             = code_q;
      bus.cpu_busy       = 1'b0;
      bus.cpu_done       = 1'b0;
      bus.cpu_fault      = 1'b0;
      bus.cpu_fault_code = code_q;
      bus.cpu_rdata      = rdata_q;
      bus.mem_req        = 1'b0;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = '0;
      bus.mem_wdata      = '0;
      bus.mem_byte_en    = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req) begin
               if (bad_size) begin
                  state_d = S_FAULT;
                  code_d  = 2'd2;
               end else if (misaligned) begin
                  state_d = S_FAULT;
                  code_d  = 2'd1;
               end else begin
                  state_d = S_BUSY;
                  code_d  = 2'd0;
               end
            end
         end
         S_BUSY: begin
            bus.cpu_busy    = 1'b1;
            bus.mem_req     = 1'b1;
            bus.mem_we      = we_q;
            bus.mem_addr    = addr_q;
            bus.mem_wdata   = wdata_q;
            bus.mem_byte_en = be_q;
            // A late ack on the final allowed cycle still completes the access.
            if (bus.mem_ack) begin
               state_d = S_DONE;
            end else if (timeout_hit) begin
               state_d = S_FAULT;
               code_d  = 2'd3;
            end
         end
         S_DONE: begin
            bus.cpu_done = 1'b1;
            state_d      = S_IDLE;
         end
         S_FAULT: begin
            bus.cpu_fault = 1'b1;
            state_d       = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         code_q  <= 2'd0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= '0;
         sext_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         if (state_q == S_BUSY) begin
            cnt_q <= cnt_q + CW'(1);
         end else begin
            cnt_q <= '0;
         end
         if (accept) begin
            we_q    <= bus.cpu_access_type;
            size_q  <= bus.cpu_access_size;
            off_q   <= req_off;
            sext_q  <= req_sext;
            addr_q  <= {bus.cpu_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end
         if ((state_q == S_BUSY) && bus.mem_ack) begin
            rdata_q <= we_q ? '0 : rd_ext;
         end
      end
   end
endmodule
